pipeline_ctrl: RTL

Central pipeline controller for the five-stage core. Arbitrates stall requests from ID (load-use), EX (multi-cycle operations such as madd/msub/div) and MEM (memory wait), sequences multi-cycle EX operations with an internal down-counter, and issues the flush/new-PC pair on exceptions. Its `stall` vector drives the hold inputs of the PC register and of the if_id, id_ex, ex_mem and mem_wb pipeline registers.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/pipeline_ctrl_mc_timer.sv | 71 +++++++
 rtl/pipeline_ctrl.sv | 65 ++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall hold vectors, timer states, default widths.
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 4;

    // Hold vectors, bit 0 = PC ... bit 5 = WB; each request holds everything upstream of its bubble.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_RUN  = 1'b1
    } mc_state_t;

endpackage

// File: rtl/pipeline_ctrl_mc_timer.sv
// Multi-cycle EX sequencer: holds EX for exactly N cycles, then a one-cycle registered done.
// Start is accepted combinationally; freeze holds all state, abort returns to idle without done.
module mc_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             freeze,
    input  logic             abort,
    output logic             busy,
    output logic             done
);

    mc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;

    // The done gate keeps the still-held EX instruction from relaunching itself.
    assign accept = start && (state_q == MC_IDLE) && !done_q && (cycles != '0)
                    && !abort && !freeze;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (abort) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (!freeze) begin
            done_d = 1'b0;
            if (accept) begin
                if (cycles == CNT_W'(1)) begin
                    done_d = 1'b1;
                end else begin
                    state_d = MC_RUN;
                    cnt_d   = cycles - CNT_W'(1);
                end
            end else if (state_q == MC_RUN) begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == MC_RUN) || accept;
    assign done = done_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: prioritised stall/flush generation, multi-cycle EX sequencing, stall counter.
// Stall/flush are zero-latency combinational; done is registered and held across MEM stalls.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             stallreq_mem,
    input  logic             except_valid,
    input  logic [31:0]      except_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             ex_mc_busy,
    output logic             ex_mc_done,
    output logic [31:0]      stall_cycles
);

    logic mc_busy;

    mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (ex_mc_start),
        .cycles (ex_mc_cycles),
        .freeze (stallreq_mem),
        .abort  (except_valid),
        .busy   (mc_busy),
        .done   (ex_mc_done)
    );

    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = '0;
        ex_mc_busy = 1'b0;
        if (!rst) begin
            ex_mc_busy = mc_busy;
            if (except_valid) begin
                flush  = 1'b1;
                new_pc = except_pc;
            end else if (stallreq_mem) begin
                stall = STALL_MEM;
            end else if (mc_busy) begin
                stall = STALL_EX;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
